mem_loader: RTL
===============

// Module: mem_loader
// PURPOSE
//  Boot/program loader that sits directly upstream of the 64K x 16 unified
//  memory write port. Consumes a framed byte stream (e.g. from a UART RX),
//  assembles 16-bit words and drives write/write_address/write_input one
//  word at a time. Holds the CPU (cpu_hold) while a frame is in progress.
// PARAMETERS
//  SYNC_BYTE      8'hA5  frame start marker
//  TIMEOUT_CYCLES 1024   idle cycles mid-frame before abort; 0 = no timeout
// PORTS
//  clk           in   1   system clock, all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  in_valid      in   1   in_data holds a byte this cycle
//  in_data       in   8   stream byte
//  in_ready      out  1   byte accepted when in_valid && in_ready
//  write         out  1   memory write strobe, 1 cycle per word
//  write_address out  16  memory word address
//  write_input   out  16  memory write data
//  cpu_hold      out  1   high while a frame is being received
//  done          out  1   1-cycle pulse: frame completed, checksum good
//  err           out  1   1-cycle pulse: checksum bad or timeout
// BEHAVIOUR
//  Frame: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, {D_H, D_L} x CNT, CSUM.
//  CSUM = XOR of every byte after SYNC up to (excluding) CSUM.
//  States: IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM.
//  - IDLE: byte == SYNC_BYTE -> ADDR_H, clear xor accum; any other byte
//    silently discarded, stay IDLE.
//  - ADDR_H/ADDR_L/CNT_H/CNT_L: latch byte, XOR into accum, advance.
//    After CNT_L: CNT == 0 -> CSUM, else -> DATA_H.
//  - DATA_H: latch high byte -> DATA_L. DATA_L: word = {D_H, D_L};
//    next cycle write=1, write_address=base+index (mod 2^16, 16'hFFFF
//    wraps to 16'h0000), write_input=word. Last word -> CSUM, else DATA_H.
//  - CSUM: byte == accum -> done pulse next cycle, else err pulse next
//    cycle; state -> IDLE either way.
//  - Words already written are NOT rolled back on err.
//  in_ready is 1 in every cycle except while rst is high; one byte per cycle.
//  All outputs registered. Reset: state IDLE, write=0, write_address=0,
//  write_input=0, cpu_hold=0, done=0, err=0, in_ready=0 (during rst).
//  write: exactly 1 cycle, cycle after D_L accepted; write_address and
//  write_input hold their last values otherwise.
//  cpu_hold: 1 in every cycle state != IDLE (registered; rises the cycle
//  after SYNC accepted, falls the same cycle done/err pulses).
//  Timeout: counter cleared on each accepted byte and in IDLE; if
//  TIMEOUT_CYCLES != 0 and TIMEOUT_CYCLES consecutive cycles pass without
//  in_valid while state != IDLE -> err pulse, state IDLE.
//  Simultaneous: byte arriving the cycle timeout expires is accepted
//  (timeout not raised). SYNC_BYTE inside a frame is ordinary data.
//  Reset mid-frame: abort silently, no done/err, no further write.
//  CNT field is in words; max 65535 words; addresses wrap, no error.
// TESTING
//  1 Frame A5 01 00 00 02 12 34 AB CD CSUM=0x00^... (correct) -> writes
//    0x0100<=0x1234, 0x0101<=0xABCD, done pulse, cpu_hold low after.
//  2 Same frame, CSUM byte off by 1 -> both writes occur, err pulse,
//    no done; next valid frame still loads.
//  3 Bytes 00 FF 3C then A5 FF FF 00 02 ... -> junk ignored; writes to
//    0xFFFF then 0x0000 (wrap), done.
//  4 A5 00 10 00 00 CSUM=0x10 -> no write, done pulse; cpu_hold 5 cycles.
//  5 TIMEOUT_CYCLES=8: A5 00 20, then in_valid low 8 cycles -> err pulse,
//    cpu_hold low, no write; byte on 8th idle cycle instead -> no err.
//  6 rst high mid DATA_L -> no write, no done/err, outputs 0, IDLE.

Source files
------------

// File: rtl/mem_loader_if.sv
// Byte-stream input, memory write port and status lines of the boot loader.
// master: the side that feeds bytes and observes memory writes/status.
// slave:  the loader itself.
interface mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        write;
  logic [15:0] write_address;
  logic [15:0] write_input;
  logic        cpu_hold;
  logic        done;
  logic        err;

  modport master (
    output in_valid, in_data,
    input  in_ready, write, write_address, write_input, cpu_hold, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, write, write_address, write_input, cpu_hold, done, err
  );
endinterface

// File: rtl/mem_loader.sv
// Boot/program loader: parses a framed byte stream
// (SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, {D_H, D_L} x CNT, CSUM) and writes
// 16-bit words into memory one per strobe, holding the CPU while a frame
// is in flight. CSUM is the XOR of every byte between SYNC and CSUM.
module mem_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic       clk,
  input logic       rst,
  mem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] base_addr;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [7:0]  data_hi;
  logic [7:0]  accum;
  logic [31:0] tmo_cnt;

  logic        accept;
  logic        timeout_hit;
  logic        last_word;
  logic        write_d, done_d, err_d, hold_d;
  logic [15:0] waddr_d, wdata_d;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_word = (word_idx == word_cnt - 16'd1);

  // Timeout fires on the TIMEOUT_CYCLES-th consecutive cycle with no byte;
  // a byte arriving in that very cycle wins because in_valid masks it.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                       !bus.in_valid && (tmo_cnt == TIMEOUT_CYCLES - 1);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for every flop so all registers update
    // from the same pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: advance one field per accepted byte.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch inferred.
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = IDLE;
    end else if (accept) begin
      unique case (state)
        IDLE:    if (bus.in_data == SYNC_BYTE) state_nxt = ADDR_H;
        ADDR_H:  state_nxt = ADDR_L;
        ADDR_L:  state_nxt = CNT_H;
        CNT_H:   state_nxt = CNT_L;
        CNT_L:   state_nxt = ({word_cnt[15:8], bus.in_data} == 16'd0) ? CSUM : DATA_H;
        DATA_H:  state_nxt = DATA_L;
        DATA_L:  state_nxt = last_word ? CSUM : DATA_H;
        CSUM:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    write_d = accept && (state == DATA_L);
    waddr_d = write_d ? base_addr + word_idx : bus.write_address;
    wdata_d = write_d ? {data_hi, bus.in_data} : bus.write_input;
    done_d  = accept && (state == CSUM) && (bus.in_data == accum);
    err_d   = (accept && (state == CSUM) && (bus.in_data != accum)) || timeout_hit;
    hold_d  = (state_nxt != IDLE);
  end

  // Output registers; address and data hold between write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready      <= 1'b0;
      bus.write         <= 1'b0;
      bus.write_address <= 16'h0000;
      bus.write_input   <= 16'h0000;
      bus.cpu_hold      <= 1'b0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      bus.in_ready      <= 1'b1;
      bus.write         <= write_d;
      bus.write_address <= waddr_d;
      bus.write_input   <= wdata_d;
      bus.cpu_hold      <= hold_d;
      bus.done          <= done_d;
      bus.err           <= err_d;
    end
  end

  // Frame fields, running checksum, word index and idle-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr <= 16'h0000;
      word_cnt  <= 16'h0000;
      word_idx  <= 16'h0000;
      data_hi   <= 8'h00;
      accum     <= 8'h00;
      tmo_cnt   <= 32'd0;
    end else begin
      if (accept) begin
        unique case (state)
          IDLE: if (bus.in_data == SYNC_BYTE) begin
            accum    <= 8'h00;
            word_idx <= 16'h0000;
          end
          ADDR_H: begin base_addr[15:8] <= bus.in_data; accum <= accum ^ bus.in_data; end
          ADDR_L: begin base_addr[7:0]  <= bus.in_data; accum <= accum ^ bus.in_data; end
          CNT_H:  begin word_cnt[15:8]  <= bus.in_data; accum <= accum ^ bus.in_data; end
          CNT_L:  begin word_cnt[7:0]   <= bus.in_data; accum <= accum ^ bus.in_data; end
          DATA_H: begin data_hi         <= bus.in_data; accum <= accum ^ bus.in_data; end
          DATA_L: begin word_idx <= word_idx + 16'd1;   accum <= accum ^ bus.in_data; end
          CSUM:   ;
          default: ;
        endcase
      end
      if (state == IDLE || accept) tmo_cnt <= 32'd0;
      else                         tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

endmodule
